ysyx_210544_exe_dispatch: RTL and testbench

//  Parametrised execute stage between decode and memory stages. Latches one decoded instruction, dispatches it to one of
//  N_CH execute channels (ch0 = single-cycle ALU, others multi-cycle, e.g. exception, mul/div), waits for that channel's done,

---
 rtl/ysyx_210544_exe_dispatch_pkg.sv | 19 +
 rtl/ysyx_210544_exe_ch_mux.sv | 35 +++
 rtl/ysyx_210544_exe_dispatch.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_210544_exe_dispatch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210544_exe_dispatch_pkg.sv
// Shared definitions for the execute-stage dispatcher: default bus width,
// system opcodes routed to the exception channel, FSM states and the
// interrupt code reported for a timer-interrupt dispatch.
package ysyx_210544_exe_dispatch_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [7:0]  INST_ECALL = 8'h50;
    localparam logic [7:0]  INST_MRET  = 8'h51;

    localparam logic [31:0] INTR_TIMER = 32'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } exe_state_t;

endpackage

// File: rtl/ysyx_210544_exe_ch_mux.sv
// Combinational N_CH-way selector: picks done, rd result and jump request of
// the channel the current instruction was dispatched to.
module ysyx_210544_exe_ch_mux #(
    parameter int XLEN = 64,
    parameter int N_CH = 4
) (
    input  logic [$clog2(N_CH)-1:0] sel,
    input  logic [N_CH-1:0]         ch_done,
    input  logic [N_CH*XLEN-1:0]    ch_wdata,
    input  logic [N_CH-1:0]         ch_jmp,
    input  logic [N_CH*XLEN-1:0]    ch_jmpaddr,
    output logic                    sel_done,
    output logic [XLEN-1:0]         sel_wdata,
    output logic                    sel_jmp,
    output logic [XLEN-1:0]         sel_jmpaddr
);

    // Select the fields of channel 'sel'; an unmatched index reads as zero.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        sel_done    = 1'b0;
        sel_wdata   = '0;
        sel_jmp     = 1'b0;
        sel_jmpaddr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i) begin
                sel_done    = ch_done[i];
                sel_wdata   = ch_wdata[i*XLEN +: XLEN];
                sel_jmp     = ch_jmp[i];
                sel_jmpaddr = ch_jmpaddr[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_210544_exe_dispatch.sv
// Execute-stage dispatcher: latches one decoded instruction, starts one
// execute channel, waits for its done and holds the result under req/ack.
// A pending timer interrupt at accept redirects the instruction to EXC_CH.
// Optional feature: define EXE_TIMEOUT_EN for a BUSY watchdog driving o_tmo.
module ysyx_210544_exe_dispatch
    import ysyx_210544_exe_dispatch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int N_CH    = 4,
    parameter int EXC_CH  = 1,
    parameter int TMO_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_dec_req,
    output logic                    o_dec_ack,
    output logic                    o_exe_req,
    input  logic                    i_exe_ack,
    input  logic [7:0]              i_opcode,
    input  logic [$clog2(N_CH)-1:0] i_ch_id,
    input  logic [XLEN-1:0]         i_pc,
    input  logic [31:0]             i_inst,
    input  logic [XLEN-1:0]         i_op1,
    input  logic [XLEN-1:0]         i_op2,
    input  logic [XLEN-1:0]         i_op3,
    input  logic [4:0]              i_rd,
    input  logic                    i_rd_wen,
    input  logic                    i_int_pend,
    output logic [N_CH-1:0]         o_ch_start,
    output logic [7:0]              o_ch_opcode,
    output logic [XLEN-1:0]         o_ch_pc,
    output logic [XLEN-1:0]         o_ch_op1,
    output logic [XLEN-1:0]         o_ch_op2,
    output logic [XLEN-1:0]         o_ch_op3,
    input  logic [N_CH-1:0]         i_ch_done,
    input  logic [N_CH*XLEN-1:0]    i_ch_wdata,
    input  logic [N_CH-1:0]         i_ch_jmp,
    input  logic [N_CH*XLEN-1:0]    i_ch_jmpaddr,
    output logic [XLEN-1:0]         o_pc,
    output logic [31:0]             o_inst,
    output logic [4:0]              o_rd,
    output logic                    o_rd_wen,
    output logic [XLEN-1:0]         o_rd_wdata,
    output logic                    o_pc_jmp,
    output logic [XLEN-1:0]         o_pc_jmpaddr,
    output logic [31:0]             o_intr_no,
    output logic                    o_tmo
);

    localparam int            CW      = $clog2(N_CH);
    localparam logic [CW-1:0] EXC_SEL = CW'(EXC_CH);

    if (N_CH < 2 || EXC_CH >= N_CH || TMO_CYC < 1) begin : g_bad_param
        $error("ysyx_210544_exe_dispatch: illegal parameter set");
    end

    exe_state_t      state_q, state_d;
    logic            accept;
    logic [CW-1:0]   ch_in;

    logic [7:0]      lat_opcode;
    logic [XLEN-1:0] lat_pc, lat_op1, lat_op2, lat_op3;
    logic [31:0]     lat_inst;
    logic [4:0]      lat_rd;
    logic            lat_rd_wen;
    logic [CW-1:0]   lat_ch;
    logic            lat_intr;
    logic [N_CH-1:0] start_q;

    logic [XLEN-1:0] res_wdata, res_jmpaddr;
    logic            res_jmp;

    logic            sel_done, sel_jmp;
    logic [XLEN-1:0] sel_wdata, sel_jmpaddr;
    logic            tmo_fire, tmo_hit;

    assign accept = i_dec_req & o_dec_ack;
    // Interrupt wins over the decoder's choice; an index past the last channel falls back to the ALU.
    assign ch_in  = i_int_pend ? EXC_SEL : ((int'(i_ch_id) >= N_CH) ? '0 : i_ch_id);

    ysyx_210544_exe_ch_mux #(
        .XLEN (XLEN),
        .N_CH (N_CH)
    ) u_ch_mux (
        .sel         (lat_ch),
        .ch_done     (i_ch_done),
        .ch_wdata    (i_ch_wdata),
        .ch_jmp      (i_ch_jmp),
        .ch_jmpaddr  (i_ch_jmpaddr),
        .sel_done    (sel_done),
        .sel_wdata   (sel_wdata),
        .sel_jmp     (sel_jmp),
        .sel_jmpaddr (sel_jmpaddr)
    );

`ifdef EXE_TIMEOUT_EN
    localparam int TW = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    // Fires once TMO_CYC BUSY cycles have passed without the channel's done.
    assign tmo_fire = (state_q == ST_BUSY) && !sel_done && (tmo_cnt == TW'(TMO_CYC - 1));
    assign tmo_hit  = tmo_flag;

    // Watchdog counter and sticky timeout flag, dropped when the result is acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state_q == ST_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_fire) begin
                tmo_flag <= 1'b1;
            end else if (state_q == ST_DONE && i_exe_ack) begin
                tmo_flag <= 1'b0;
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign tmo_hit  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BUSY waits on the selected done, DONE chains straight into BUSY on ack + new request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (sel_done || tmo_fire) state_d = ST_DONE;
            ST_DONE: if (i_exe_ack) state_d = i_dec_req ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction latch, one-cycle start pulse and result capture.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well, since the broadcast buses must read 0 after reset.
        if (rst) begin
            lat_opcode  <= '0;
            lat_pc      <= '0;
            lat_inst    <= '0;
            lat_op1     <= '0;
            lat_op2     <= '0;
            lat_op3     <= '0;
            lat_rd      <= '0;
            lat_rd_wen  <= 1'b0;
            lat_ch      <= '0;
            lat_intr    <= 1'b0;
            start_q     <= '0;
            res_wdata   <= '0;
            res_jmp     <= 1'b0;
            res_jmpaddr <= '0;
        end else begin
            start_q <= '0;
            if (accept) begin
                lat_opcode <= i_opcode;
                lat_pc     <= i_pc;
                lat_inst   <= i_inst;
                lat_op1    <= i_op1;
                lat_op2    <= i_op2;
                lat_op3    <= i_op3;
                lat_rd     <= i_rd;
                lat_rd_wen <= i_rd_wen;
                lat_ch     <= ch_in;
                lat_intr   <= i_int_pend;
                start_q    <= N_CH'(1) << ch_in;
            end
            if (state_q == ST_BUSY && sel_done) begin
                res_wdata   <= sel_wdata;
                res_jmp     <= sel_jmp;
                res_jmpaddr <= sel_jmpaddr;
            end
        end
    end

    assign o_ch_start  = start_q;
    assign o_ch_opcode = lat_opcode;
    assign o_ch_pc     = lat_pc;
    assign o_ch_op1    = lat_op1;
    assign o_ch_op2    = lat_op2;
    assign o_ch_op3    = lat_op3;

    // Handshake and result outputs; results are visible only while DONE.
    always_comb begin
        o_dec_ack    = (state_q == ST_IDLE) || (state_q == ST_DONE && i_exe_ack);
        o_exe_req    = (state_q == ST_DONE);
        o_pc         = '0;
        o_inst       = '0;
        o_rd         = '0;
        o_rd_wen     = 1'b0;
        o_rd_wdata   = '0;
        o_pc_jmp     = 1'b0;
        o_pc_jmpaddr = '0;
        o_intr_no    = '0;
        o_tmo        = 1'b0;
        if (state_q == ST_DONE) begin
            o_pc         = lat_pc;
            o_inst       = lat_inst;
            o_rd         = (lat_ch == EXC_SEL) ? '0 : lat_rd;
            o_rd_wen     = lat_rd_wen && (lat_ch != EXC_SEL) && !tmo_hit;
            o_rd_wdata   = res_wdata;
            o_pc_jmp     = res_jmp && !tmo_hit;
            o_pc_jmpaddr = res_jmpaddr;
            o_intr_no    = (lat_intr && !tmo_hit) ? INTR_TIMER : '0;
            o_tmo        = tmo_hit;
        end
    end

endmodule

// File: tb/tb_ysyx_210544_exe_dispatch.sv
// Bench for ysyx_210544_exe_dispatch: directed and random transactions,
// the bench plays all execute channels and predicts every output.
// Define EXE_TIMEOUT_EN to also exercise the watchdog.
module tb_ysyx_210544_exe_dispatch;
    import ysyx_210544_exe_dispatch_pkg::*;

    localparam int XLEN    = 64;
    localparam int N_CH    = 4;
    localparam int EXC_CH  = 1;
    localparam int TMO_CYC = 255;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 dec_req, dec_ack, exe_req, exe_ack;
    logic [7:0]           opcode;
    logic [1:0]           ch_id;
    logic [XLEN-1:0]      pc, op1, op2, op3;
    logic [31:0]          inst;
    logic [4:0]           rd;
    logic                 rd_wen, int_pend;
    logic [N_CH-1:0]      ch_start, ch_done, ch_jmp;
    logic [7:0]           ch_opcode;
    logic [XLEN-1:0]      ch_pc, ch_op1, ch_op2, ch_op3;
    logic [N_CH*XLEN-1:0] ch_wdata, ch_jmpaddr;
    logic [XLEN-1:0]      out_pc, out_rd_wdata, out_jmpaddr;
    logic [31:0]          out_inst, out_intr_no;
    logic [4:0]           out_rd;
    logic                 out_rd_wen, out_jmp, out_tmo;

    int total = 0;
    int bad   = 0;

    // Per-channel behaviour for the running transaction.
    logic [63:0] wd_m [N_CH];
    logic        jm_m [N_CH];
    logic [63:0] ja_m [N_CH];

    ysyx_210544_exe_dispatch #(
        .XLEN(XLEN), .N_CH(N_CH), .EXC_CH(EXC_CH), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .i_dec_req(dec_req), .o_dec_ack(dec_ack),
        .o_exe_req(exe_req), .i_exe_ack(exe_ack),
        .i_opcode(opcode), .i_ch_id(ch_id), .i_pc(pc), .i_inst(inst),
        .i_op1(op1), .i_op2(op2), .i_op3(op3), .i_rd(rd), .i_rd_wen(rd_wen),
        .i_int_pend(int_pend),
        .o_ch_start(ch_start), .o_ch_opcode(ch_opcode), .o_ch_pc(ch_pc),
        .o_ch_op1(ch_op1), .o_ch_op2(ch_op2), .o_ch_op3(ch_op3),
        .i_ch_done(ch_done), .i_ch_wdata(ch_wdata), .i_ch_jmp(ch_jmp),
        .i_ch_jmpaddr(ch_jmpaddr),
        .o_pc(out_pc), .o_inst(out_inst), .o_rd(out_rd), .o_rd_wen(out_rd_wen),
        .o_rd_wdata(out_rd_wdata), .o_pc_jmp(out_jmp), .o_pc_jmpaddr(out_jmpaddr),
        .o_intr_no(out_intr_no), .o_tmo(out_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_ch();
        for (int i = 0; i < N_CH; i++) begin
            ch_wdata[i*XLEN +: XLEN]   = wd_m[i];
            ch_jmp[i]                  = jm_m[i];
            ch_jmpaddr[i*XLEN +: XLEN] = ja_m[i];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_exe_req"}, exe_req, 0);
        check({tag, "_dec_ack"}, dec_ack, 1);
        check({tag, "_start"}, ch_start, 0);
        check({tag, "_rd_wdata"}, out_rd_wdata, 0);
        check({tag, "_pc"}, out_pc, 0);
    endtask

    // One instruction: offered in the current cycle, selected channel raises done
    // 'delay' cycles after the start cycle, ack held off 'ack_wait' cycles.
    // Returns in the final DONE cycle with ack asserted, before its clock edge.
    task automatic send(input logic [1:0] id, input logic pend, input int delay,
                        input int ack_wait, input logic [63:0] a, input logic [63:0] b);
        int          exp_ch;
        logic [63:0] e_pc, e_op3, e_wd, e_ja;
        logic [31:0] e_inst;
        logic [7:0]  e_opc;
        logic [4:0]  e_rd;
        logic        e_wen, e_jmp;
        logic [3:0]  onehot;

        exp_ch = pend ? EXC_CH : int'(id);
        onehot = 4'(1 << exp_ch);
        e_pc   = rnd64();
        e_op3  = rnd64();
        e_inst = $urandom;
        e_rd   = 5'($urandom_range(0, 31));
        e_wen  = 1'($urandom_range(0, 1));
        e_opc  = (int'(id) == EXC_CH) ? (($urandom_range(0, 1) != 0) ? INST_ECALL : INST_MRET)
                                      : 8'($urandom_range(0, 255));
        for (int i = 0; i < N_CH; i++) begin
            wd_m[i] = rnd64();
            jm_m[i] = 1'($urandom_range(0, 1));
            ja_m[i] = rnd64();
        end
        wd_m[0] = a + b;  // channel 0 behaves as an adder
        drive_ch();
        dec_req = 1'b1; ch_id = id; int_pend = pend; opcode = e_opc;
        pc = e_pc; inst = e_inst; op1 = a; op2 = b; op3 = e_op3;
        rd = e_rd; rd_wen = e_wen; ch_done = '0;
        #1;
        check("accept_dec_ack", dec_ack, 1);
        next_cycle();
        // Inputs change after accept; only latched values may matter now.
        exe_ack = 1'b0; dec_req = 1'b0; int_pend = ~pend;
        pc = rnd64(); op1 = rnd64(); op2 = rnd64(); opcode = 8'($urandom);
        for (int c = 1; c <= delay + 1; c++) begin
            ch_done = (4'($urandom) & ~onehot) | ((c == delay + 1) ? onehot : 4'b0);
            #1;
            check("busy_start", ch_start, (c == 1) ? onehot : 4'b0);
            check("busy_exe_req", exe_req, 0);
            check("busy_dec_ack", dec_ack, 0);
            if (c == 1) begin
                check("bcast_opcode", ch_opcode, e_opc);
                check("bcast_pc", ch_pc, e_pc);
                check("bcast_op1", ch_op1, a);
                check("bcast_op2", ch_op2, b);
                check("bcast_op3", ch_op3, e_op3);
            end
            next_cycle();
        end
        e_wd  = wd_m[exp_ch];
        e_jmp = jm_m[exp_ch];
        e_ja  = ja_m[exp_ch];
        for (int w = 0; w <= ack_wait; w++) begin
            for (int i = 0; i < N_CH; i++) begin
                wd_m[i] = rnd64(); jm_m[i] = ~jm_m[i]; ja_m[i] = rnd64();
            end
            drive_ch();
            ch_done = 4'($urandom);
            exe_ack = (w == ack_wait);
            #1;
            check("done_exe_req", exe_req, 1);
            check("done_dec_ack", dec_ack, exe_ack);
            check("done_start", ch_start, 0);
            check("done_pc", out_pc, e_pc);
            check("done_inst", out_inst, e_inst);
            check("done_rd", out_rd, (exp_ch == EXC_CH) ? 5'd0 : e_rd);
            check("done_rd_wen", out_rd_wen, e_wen && (exp_ch != EXC_CH));
            check("done_rd_wdata", out_rd_wdata, e_wd);
            check("done_jmp", out_jmp, e_jmp);
            check("done_jmpaddr", out_jmpaddr, e_ja);
            check("done_intr_no", out_intr_no, pend ? 32'd7 : 32'd0);
            check("done_tmo", out_tmo, 0);
            if (w < ack_wait) next_cycle();
        end
    endtask

    // Leave the final DONE cycle with no new request and confirm the return to IDLE.
    task automatic finish_idle();
        dec_req = 1'b0;
        next_cycle();
        exe_ack = 1'b0;
        ch_done = '0;
        #1;
        check_idle("idle");
    endtask

    initial begin
        logic b2b;
        rst = 1'b1; dec_req = 0; exe_ack = 0; opcode = 0; ch_id = 0; pc = 0; inst = 0;
        op1 = 0; op2 = 0; op3 = 0; rd = 0; rd_wen = 0; int_pend = 0; ch_done = 0;
        ch_wdata = 0; ch_jmp = 0; ch_jmpaddr = 0;
        next_cycle();
        next_cycle();
        check_idle("reset");
        check("reset_rd_wen", out_rd_wen, 0);
        check("reset_jmp", out_jmp, 0);
        check("reset_intr_no", out_intr_no, 0);
        check("reset_tmo", out_tmo, 0);
        check("reset_bcast_pc", ch_pc, 0);
        rst = 1'b0;
        next_cycle();

        // ALU add, done in the start cycle, immediate ack.
        send(2'd0, 1'b0, 0, 0, 64'd5, 64'd7);
        check("add_result", out_rd_wdata, 64'd12);
        finish_idle();
        // Slow channel 2 with ack held back three cycles.
        send(2'd2, 1'b0, 10, 3, rnd64(), rnd64());
        finish_idle();
        // Interrupt redirects an ALU instruction to the exception channel.
        send(2'd0, 1'b1, 2, 1, rnd64(), rnd64());
        // Back-to-back into a new instruction.
        send(2'd3, 1'b0, 1, 0, rnd64(), rnd64());
        finish_idle();

        // Random mix, half of them chained without an IDLE cycle.
        b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(0, 10),
                 $urandom_range(0, 3), rnd64(), rnd64());
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) finish_idle();
        end
        if (b2b) finish_idle();

        // Reset while BUSY drops the instruction; a late done is ignored.
        dec_req = 1'b1; ch_id = 2'd2; int_pend = 1'b0;
        #1;
        check("rst_busy_accept", dec_ack, 1);
        next_cycle();
        dec_req = 1'b0; rst = 1'b1;
        #1;
        check("rst_busy_start", ch_start, 4'b0100);
        next_cycle();
        rst = 1'b0; ch_done = 4'b0100;
        #1;
        check_idle("rst_busy_after");
        next_cycle();
        #1;
        check_idle("rst_busy_late_done");
        ch_done = '0;

        // Reset on the accept edge: no start pulse follows.
        dec_req = 1'b1; rst = 1'b1; ch_id = 2'd3;
        next_cycle();
        dec_req = 1'b0; rst = 1'b0;
        #1;
        check_idle("rst_accept");

`ifdef EXE_TIMEOUT_EN
        // Channel 3 never finishes: watchdog result after TMO_CYC BUSY cycles.
        for (int i = 0; i < N_CH; i++) begin
            wd_m[i] = rnd64(); jm_m[i] = 1'b1; ja_m[i] = rnd64();
        end
        drive_ch();
        dec_req = 1'b1; ch_id = 2'd3; int_pend = 1'b0; rd_wen = 1'b1; ch_done = '0;
        #1;
        check("tmo_accept", dec_ack, 1);
        next_cycle();
        dec_req = 1'b0;
        for (int c = 1; c <= TMO_CYC; c++) begin
            ch_done = 4'($urandom) & 4'b0111;
            #1;
            check("tmo_wait_exe_req", exe_req, 0);
            next_cycle();
        end
        #1;
        check("tmo_exe_req", exe_req, 1);
        check("tmo_flag", out_tmo, 1);
        check("tmo_rd_wen", out_rd_wen, 0);
        check("tmo_jmp", out_jmp, 0);
        check("tmo_intr_no", out_intr_no, 0);
        exe_ack = 1'b1;
        next_cycle();
        exe_ack = 1'b0;
        ch_done = '0;
        #1;
        check("tmo_cleared", out_tmo, 0);
        check_idle("tmo_idle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
